// File: rtl/level_progress_ctrl.sv
// Level progression controller: tracks bird life, detects a cleared level,
// runs the inter-level pause, and pulses level_up or latches game_won.
module level_progress_ctrl #(
  parameter int PAUSE_FRAMES = 60,
  parameter int MAX_LEVEL    = 7
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic       startOfFrame,
  input  logic [1:0] bird_hit,
  input  logic [3:0] bird_life,
  input  logic       number_of_birds,
  output logic       level_up,
  output logic [2:0] level_num,
  output logic [3:0] lives_b0,
  output logic [3:0] lives_b1,
  output logic [1:0] bird_alive,
  output logic       level_pause,
  output logic       game_won
);

  localparam logic [7:0] PAUSE_LAST = 8'(PAUSE_FRAMES);
  localparam logic [2:0] LAST_LEVEL = 3'(MAX_LEVEL);

  typedef enum logic [2:0] {
    S_LOAD    = 3'd0,
    S_PLAY    = 3'd1,
    S_PAUSE   = 3'd2,
    S_ADVANCE = 3'd3,
    S_WON     = 3'd4
  } state_t;

  state_t     state_q;
  logic [7:0] pause_cnt_q;
  logic [1:0] hit_flag_q;
  logic [3:0] lives0_q;
  logic [3:0] lives1_q;
  logic [2:0] level_num_q;
  logic       level_up_q;
  logic       pause_q;
  logic       won_q;

  logic       accept0;
  logic       accept1;
  logic       all_dead;
  logic [1:0] hit_flag_d;
  logic [7:0] pause_cnt_d;

  // A frame boundary re-arms a bird, so a hit coinciding with it still counts.
  always_comb begin
    accept0     = bird_hit[0] && (lives0_q != 4'd0) && (!hit_flag_q[0] || startOfFrame);
    accept1     = bird_hit[1] && (lives1_q != 4'd0) && (!hit_flag_q[1] || startOfFrame);
    hit_flag_d  = (startOfFrame ? 2'b00 : hit_flag_q) | {accept1, accept0};
    all_dead    = (lives0_q == 4'd0) && (lives1_q == 4'd0);
    pause_cnt_d = pause_cnt_q + 8'd1;
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q     <= S_LOAD;
      pause_cnt_q <= 8'd0;
      hit_flag_q  <= 2'b00;
      lives0_q    <= 4'd0;
      lives1_q    <= 4'd0;
      level_num_q <= 3'd0;
      level_up_q  <= 1'b0;
      pause_q     <= 1'b0;
      won_q       <= 1'b0;
    end else begin
      case (state_q)
        S_LOAD: begin
          lives0_q   <= bird_life;
          lives1_q   <= number_of_birds ? bird_life : 4'd0;
          hit_flag_q <= 2'b00;
          level_up_q <= 1'b0;
          pause_q    <= 1'b0;
          state_q    <= S_PLAY;
        end
        S_PLAY: begin
          if (all_dead) begin
            hit_flag_q  <= 2'b00;
            pause_cnt_q <= 8'd0;
            pause_q     <= 1'b1;
            if (level_num_q < LAST_LEVEL) begin
              state_q <= S_PAUSE;
            end else begin
              won_q   <= 1'b1;
              state_q <= S_WON;
            end
          end else begin
            if (accept0) lives0_q <= lives0_q - 4'd1;
            if (accept1) lives1_q <= lives1_q - 4'd1;
            hit_flag_q <= hit_flag_d;
          end
        end
        S_PAUSE: begin
          if (startOfFrame) begin
            pause_cnt_q <= pause_cnt_d;
            if (pause_cnt_d == PAUSE_LAST) begin
              level_up_q <= 1'b1;
              pause_q    <= 1'b0;
              state_q    <= S_ADVANCE;
            end
          end
        end
        S_ADVANCE: begin
          level_up_q  <= 1'b0;
          level_num_q <= level_num_q + 3'd1;
          state_q     <= S_LOAD;
        end
        S_WON: begin
          level_up_q <= 1'b0;
          pause_q    <= 1'b1;
          won_q      <= 1'b1;
        end
        default: state_q <= S_LOAD;
      endcase
    end
  end

  assign level_up    = level_up_q;
  assign level_num   = level_num_q;
  assign lives_b0    = lives0_q;
  assign lives_b1    = lives1_q;
  assign bird_alive  = {lives1_q != 4'd0, lives0_q != 4'd0};
  assign level_pause = pause_q;
  assign game_won    = won_q;

endmodule
